// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   word_t        - 32-bit instruction word
//   fetch_state_t - fetch FSM state (RUN issues requests, FLUSH drains stale responses)
//   fetch_entry_t - prefetch FIFO payload: instruction word plus its fetch address
//   PC_STEP       - byte increment between sequential fetches
//   PC_MAX_W      - widest fetch address the FIFO payload can carry
package fetch_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned PC_MAX_W = 32;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer between instruction memory responses and the decoder.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr         - synchronous clear (redirect); wins over push and pop
//   push, data  - write one entry
//   pop         - remove the head entry (ignored when empty)
//   head        - registered head entry (stale contents when empty)
//   count       - number of valid entries
// DEPTH must be a power of 2 so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   push,
  input  fetch_entry_t           data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            empty;
  logic            full;
  logic            pop_ok;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_ok = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clr && push) mem[wr_ptr] <= data;
  end

  // Credit accounting upstream must never push into a full FIFO without a pop.
  always_ff @(posedge clk) begin
    if (!reset && !clr) assert (!(push && full && !pop_ok));
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end (producer of instr / instr_pc).
// Holds the fetch PC, issues word requests to instruction memory, buffers the
// in-order responses in a prefetch FIFO and flushes on a redirect (pc_src).
// Ports:
//   clk, reset                           - clock, synchronous active-high reset
//   mem_req_valid/addr/ready             - request channel (valid is not sticky)
//   mem_resp_valid/data                  - in-order responses, >= 1 cycle latency
//   instr_valid/instr/instr_pc/ready     - FIFO head towards the decoder
//   redirect, redirect_pc                - taken branch; redirect_pc[1:0] ignored
//   perf_fetched, perf_squashed          - saturating counters (FETCH_PERF_EN only)
// Handshake: a transfer happens on a cycle where valid and ready are both high;
// valid may fall without a transfer and carries no obligation to stay up.
// Optional feature macro: FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed
`endif
);

  localparam int TW = $clog2(DEPTH);
  localparam int CW = TW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_n;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     drop_cnt_n;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       inflight;
  logic [ADDR_W-1:0] tag_mem [DEPTH];
  logic [TW-1:0]     tag_wr;
  logic [TW-1:0]     tag_rd;
  logic              accept;
  logic              resp_fire;
  logic              resp_drop;
  logic              resp_keep;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit check: FIFO entries plus in-flight requests never exceed DEPTH,
  // so every response is guaranteed a free FIFO slot.
  assign inflight      = (CW + 1)'(outstanding) + (CW + 1)'(fifo_count);
  assign mem_req_valid = !reset && (state == RUN) && !redirect && (inflight < DEPTH_L);
  assign mem_req_addr  = fetch_pc;
  assign accept        = mem_req_valid && mem_req_ready;

  // Responses are only meaningful while something is outstanding; anything
  // else (e.g. a late beat across reset) is ignored.
  assign resp_fire     = mem_resp_valid && (outstanding != '0);
  assign resp_drop     = resp_fire && (redirect || (drop_cnt != '0));
  assign resp_keep     = resp_fire && !resp_drop;
  assign outstanding_n = outstanding + CW'(accept) - CW'(resp_fire);
  assign drop_cnt_n    = (resp_drop && !redirect) ? drop_cnt - CW'(1) : drop_cnt;

  assign instr_valid   = (fifo_count != '0);
  assign pop           = instr_valid && instr_ready && !redirect;
  assign instr         = instr_valid ? head.instr : '0;
  assign instr_pc      = instr_valid ? head.pc[ADDR_W-1:0] : '0;

  assign push_entry.instr = mem_resp_data;
  assign push_entry.pc    = PC_MAX_W'(tag_mem[tag_rd]);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (redirect),
    .push  (resp_keep),
    .data  (push_entry),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

  // Tag queue: address of every accepted request, consumed in response order.
  always_ff @(posedge clk) begin
    if (!reset && accept) tag_mem[tag_wr] <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      outstanding <= outstanding_n;
      if (accept) begin
        tag_wr   <= tag_wr + TW'(1);
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
      if (resp_fire) tag_rd <= tag_rd + TW'(1);
      if (redirect) begin
        // No request is issued this cycle, so outstanding_n is exactly the
        // in-flight count minus any response being discarded right now.
        fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        drop_cnt <= outstanding_n;
        state    <= (outstanding_n != '0) ? FLUSH : RUN;
      end else begin
        drop_cnt <= drop_cnt_n;
        if (state == FLUSH && drop_cnt_n == '0) state <= RUN;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [CW:0] squash_inc;
  logic [32:0] squash_sum;

  assign squash_inc = (redirect ? (CW + 1)'(fifo_count) : '0) + (CW + 1)'(resp_drop);
  assign squash_sum = {1'b0, perf_squashed} + 33'(squash_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (pop && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      perf_squashed <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model
// of programmable latency. Optional counters are checked when FETCH_PERF_EN is set.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  int checks;
  int failures;
  int unsigned cyc;
  int unsigned mem_lat;
  int unsigned last_due;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } pend_t;

  pend_t       mq[$];
  logic [31:0] acc_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_data_q[$];
  logic [31:0] exp_q[$];

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_squashed  (perf_squashed)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory model and logger. Response for the coming edge is driven at +2,
  // acceptance and consumer pops are observed at +8 (just before the edge).
  initial begin
    int unsigned d;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    cyc            = 0;
    last_due       = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!reset && mq.size() > 0 && mq[0].due == cyc + 1) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(mq[0].addr);
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
      end
      #6;
      if (reset) begin
        mq.delete();
        acc_q.delete();
        pop_pc_q.delete();
        pop_data_q.delete();
        last_due       = 0;
        mem_resp_valid = 1'b0;
      end else begin
        if (mem_resp_valid) void'(mq.pop_front());
        if (mem_req_valid && mem_req_ready) begin
          d = cyc + 1 + mem_lat;
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          mq.push_back('{due: d, addr: mem_req_addr});
          acc_q.push_back(mem_req_addr);
        end
        if (instr_valid && instr_ready && !redirect) begin
          pop_pc_q.push_back(instr_pc);
          pop_data_q.push_back(instr);
        end
      end
    end
  end

  // Driver: hold reset for two edges with idle inputs; caller releases it.
  task automatic do_reset();
    reset         = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %0b exp 0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr: got %h exp 00000000", mem_req_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid: got %0b exp 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h exp 00000000", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc: got %h exp 00000000", instr_pc); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetched !== 32'h0 || perf_squashed !== 32'h0) begin failures++; $display("FAIL reset_perf: got %h/%h exp 0/0", perf_fetched, perf_squashed); end
`endif
  endtask

  task automatic test_stream();
    do_reset();
    mem_lat = 1;
    reset   = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin failures++; $display("FAIL stream_first_req: got %0b/%h exp 1/00000000", mem_req_valid, mem_req_addr); end
    tick(1);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_latency_early: got %0b exp 0", instr_valid); end
    tick(1);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin failures++; $display("FAIL stream_first_instr: got %0b/%h/%h exp 1/00000000/%h", instr_valid, instr_pc, instr, mem_word(32'h0)); end
    tick(12);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    checks++; if (acc_q.size() < 5 || pop_pc_q.size() < 5) begin failures++; $display("FAIL stream_counts: got %0d/%0d exp >=5/>=5", acc_q.size(), pop_pc_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin failures++; $display("FAIL stream_req_addr[%0d]: got %h exp %h", i, acc_q[i], exp_q[i]); end
      checks++; if (pop_pc_q[i] !== exp_q[i] || pop_data_q[i] !== mem_word(exp_q[i])) begin failures++; $display("FAIL stream_pop[%0d]: got %h/%h exp %h/%h", i, pop_pc_q[i], pop_data_q[i], exp_q[i], mem_word(exp_q[i])); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_lat     = 1;
    instr_ready = 1'b0;
    reset       = 1'b0;
    tick(10);
    checks++; if (acc_q.size() != 2) begin failures++; $display("FAIL bp_req_count: got %0d exp 2", acc_q.size()); end
    checks++; if (acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4) begin failures++; $display("FAIL bp_req_addrs: got %h/%h exp 00000000/00000004", acc_q[0], acc_q[1]); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_held_low: got %0b exp 0", mem_req_valid); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL bp_head: got %0b/%h exp 1/00000000", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    tick(8);
    checks++; if (pop_pc_q.size() < 2 || pop_pc_q[0] !== 32'h0 || pop_pc_q[1] !== 32'h4) begin failures++; $display("FAIL bp_pop_order: got %h/%h exp 00000000/00000004", pop_pc_q[0], pop_pc_q[1]); end
    checks++; if (acc_q.size() < 3 || acc_q[2] !== 32'h8) begin failures++; $display("FAIL bp_resume_addr: got %h exp 00000008", acc_q[2]); end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_lat = 3;
    reset   = 1'b0;
    tick(2);
    checks++; if (acc_q.size() != 2) begin failures++; $display("FAIL redir_inflight: got %0d exp 2", acc_q.size()); end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_no_req: got %0b exp 0", mem_req_valid); end
    tick(1);
    redirect = 1'b0;
    #1;
    checks++; if (mem_req_addr !== 32'h100 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_flush_addr: got %h/%0b exp 00000100/0", mem_req_addr, mem_req_valid); end
    tick(1);
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_flush_hold: got %0b exp 0", mem_req_valid); end
    tick(1);
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin failures++; $display("FAIL redir_resume: got %0b/%h exp 1/00000100", mem_req_valid, mem_req_addr); end
    tick(10);
    checks++; if (acc_q.size() < 3 || acc_q[2] !== 32'h100) begin failures++; $display("FAIL redir_req_after: got %h exp 00000100", acc_q[2]); end
    checks++; if (pop_pc_q.size() < 1 || pop_pc_q[0] !== 32'h100 || pop_data_q[0] !== mem_word(32'h100)) begin failures++; $display("FAIL redir_first_pop: got %h/%h exp 00000100/%h", pop_pc_q[0], pop_data_q[0], mem_word(32'h100)); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_squashed !== 32'd2) begin failures++; $display("FAIL redir_perf_squashed: got %0d exp 2", perf_squashed); end
`endif
  endtask

  task automatic test_redirect_pop_resp();
    do_reset();
    mem_lat = 1;
    reset   = 1'b0;
    tick(2);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL rpr_setup_head: got %0b/%h exp 1/00000000", instr_valid, instr_pc); end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rpr_no_req: got %0b exp 0", mem_req_valid); end
    tick(1);
    redirect = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rpr_fifo_empty: got %0b exp 0", instr_valid); end
    checks++; if (pop_pc_q.size() != 0) begin failures++; $display("FAIL rpr_pop_ignored: got %0d exp 0", pop_pc_q.size()); end
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin failures++; $display("FAIL rpr_resume: got %0b/%h exp 1/00000040", mem_req_valid, mem_req_addr); end
    tick(8);
    checks++; if (pop_pc_q.size() < 1 || pop_pc_q[0] !== 32'h40) begin failures++; $display("FAIL rpr_first_pop: got %h exp 00000040", pop_pc_q[0]); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_squashed !== 32'd2) begin failures++; $display("FAIL rpr_perf_squashed: got %0d exp 2", perf_squashed); end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    mem_lat       = 1;
    mem_req_ready = 1'b0;
    reset         = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin failures++; $display("FAIL stall_hold[%0d]: got %0b/%h exp 1/00000000", i, mem_req_valid, mem_req_addr); end
      tick(1);
    end
    checks++; if (acc_q.size() != 0) begin failures++; $display("FAIL stall_no_accept: got %0d exp 0", acc_q.size()); end
    mem_req_ready = 1'b1;
    tick(1);
    checks++; if (acc_q.size() != 1 || acc_q[0] !== 32'h0) begin failures++; $display("FAIL stall_release: got %0d/%h exp 1/00000000", acc_q.size(), acc_q[0]); end
    checks++; if (mem_req_addr !== 32'h4) begin failures++; $display("FAIL stall_pc_step: got %h exp 00000004", mem_req_addr); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    mem_lat = 3;
    reset   = 1'b0;
    tick(2);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick(1);
    redirect = 1'b0;
    tick(1);
    checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h200) begin failures++; $display("FAIL rf_in_flush: got %0b/%h exp 0/00000200", mem_req_valid, mem_req_addr); end
    reset = 1'b1;
    tick(1);
    checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin failures++; $display("FAIL rf_req_zero: got %0b/%h exp 0/00000000", mem_req_valid, mem_req_addr); end
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL rf_instr_zero: got %0b/%h/%h exp 0/0/0", instr_valid, instr, instr_pc); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetched !== 32'h0 || perf_squashed !== 32'h0) begin failures++; $display("FAIL rf_perf_zero: got %h/%h exp 0/0", perf_fetched, perf_squashed); end
`endif
    reset = 1'b0;
    tick(8);
    checks++; if (acc_q.size() < 1 || acc_q[0] !== 32'h0) begin failures++; $display("FAIL rf_restart_addr: got %h exp 00000000", acc_q[0]); end
    checks++; if (pop_pc_q.size() < 1 || pop_pc_q[0] !== 32'h0 || pop_data_q[0] !== mem_word(32'h0)) begin failures++; $display("FAIL rf_restart_pop: got %h/%h exp 00000000/%h", pop_pc_q[0], pop_data_q[0], mem_word(32'h0)); end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    mem_lat       = 1;
    reset         = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop_resp();
    test_stall();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
